// File: rtl/tetris_input_pkg.sv
// Shared definitions for the player-input path: action ids, as used by the DAS
// debouncers and the action queue.
package tetris_input_pkg;

  localparam int NUM_ACTIONS = 6;
  localparam int ACTION_ID_W = $clog2(NUM_ACTIONS);

  typedef logic [ACTION_ID_W-1:0] action_id_t;

  typedef enum logic [ACTION_ID_W-1:0] {
    MOVE_LEFT  = 3'd0,
    MOVE_RIGHT = 3'd1,
    ROTATE_CW  = 3'd2,
    ROTATE_CCW = 3'd3,
    SOFT_DROP  = 3'd4,
    HARD_DROP  = 3'd5
  } action_t;

endpackage

// File: rtl/action_fifo.sv
// Small synchronous FIFO of action ids; clear has priority over push and pop.
module action_fifo
  import tetris_input_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = $bits(action_id_t)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_eff;
  logic             pop_eff;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_eff = push & ~full;
  assign pop_eff  = pop & ~empty;
  // Empty head reads as id 0 so the output is defined straight out of reset.
  assign head_data = empty ? '0 : mem[rd_ptr];

  counter #(.WIDTH(PW)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .en    (push_eff),
    .value (wr_ptr)
  );

  counter #(.WIDTH(PW)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .en    (pop_eff),
    .value (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (push_eff && !clear) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        count <= '0;
    else if (clear) count <= '0;
    else            count <= count + CW'(push_eff) - CW'(pop_eff);
  end

endmodule

// File: rtl/counter.sv
// Free-running wrap-around counter with enable and synchronous clear.
module counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        value <= '0;
    else if (clear) value <= '0;
    else if (en)    value <= value + 1'b1;
  end

endmodule

// File: rtl/input_action_queue.sv
// Serialises DAS action pulses into one in-order valid/ready stream, with
// per-action back-pressure so each action type has at most one entry in flight.
module input_action_queue
  import tetris_input_pkg::*;
#(
  parameter int NUM_ACTIONS = tetris_input_pkg::NUM_ACTIONS,
  parameter int DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_ACTIONS-1:0]        action_pulse,
  output logic [NUM_ACTIONS-1:0]        action_valid,
  input  logic                          flush,
  output logic                          act_valid,
  input  logic                          act_ready,
  output logic [$clog2(NUM_ACTIONS)-1:0] act_id,
  output logic [$clog2(DEPTH):0]        queue_count
);

  localparam int ID_W = $clog2(NUM_ACTIONS);

  logic [NUM_ACTIONS-1:0] req;
  logic [NUM_ACTIONS-1:0] queued;
  logic [NUM_ACTIONS-1:0] grant;
  logic [NUM_ACTIONS-1:0] pop_mask;
  logic [ID_W-1:0]        grant_id;
  logic                   found;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;

  assign action_valid = ~req & ~queued & {NUM_ACTIONS{~flush}};
  assign act_valid    = ~fifo_empty;
  assign pop          = act_valid & act_ready;
  assign push         = (|req) & ~fifo_full;

  // Lowest pending index wins, giving ascending order for same-cycle pulses.
  always_comb begin
    grant_id = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_ACTIONS; i++) begin
      if (req[i] && !found) begin
        grant_id = ID_W'(i);
        found    = 1'b1;
      end
    end
  end

  assign grant    = push ? (NUM_ACTIONS'(1) << grant_id) : '0;
  assign pop_mask = pop  ? (NUM_ACTIONS'(1) << act_id)   : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req    <= '0;
      queued <= '0;
    end else if (flush) begin
      req    <= '0;
      queued <= '0;
    end else begin
      req    <= (req | (action_pulse & action_valid)) & ~grant;
      queued <= (queued & ~pop_mask) | grant;
    end
  end

  action_fifo #(.DEPTH(DEPTH), .WIDTH(ID_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data (grant_id),
    .pop       (pop),
    .head_data (act_id),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (queue_count)
  );

endmodule

// File: doc/input_action_queue.md
# input_action_queue

Collects the single-cycle action pulses from all per-button DAS debouncer instances and serialises them, in arrival order, into one valid/ready action stream consumed by the piece-movement logic. It is the game-side end of the DAS interface. It drives each DAS instance's `action_valid` back-pressure input, so at most one instance of each action type is in flight at any time. A synchronous flush drops all pending actions on piece spawn or game over.

## Interface
- `NUM_ACTIONS`, 6: number of action types / DAS instances; index = action id.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `action_pulse` in NUM_ACTIONS: single-cycle pulses from the DAS instances (`action_out`).
- `action_valid` out NUM_ACTIONS: per-action accept enable back to each DAS instance.
- `flush` in 1: synchronous clear of all pending and queued actions.
- `act_valid` out 1: head of the queue is valid.
- `act_ready` in 1: consumer accepts the head this cycle.
- `act_id` out $clog2(NUM_ACTIONS): action id at the head.
- `queue_count` out $clog2(DEPTH)+1: occupied FIFO entries (debug/verification).

## Operation
- Request latch `req[NUM_ACTIONS]`: at each edge, `req <= (req | (action_pulse & action_valid)) & ~grant`. A pulse while `action_valid[i]=0` is dropped.
- Scheduler: each cycle, if `req != 0` and the FIFO is not full, it grants the lowest set index of `req` and pushes that id. At most one push per cycle. Same-cycle pulses are enqueued in ascending index order over successive cycles.
- `queued[NUM_ACTIONS]` marks ids currently in the FIFO. Set on push, cleared on pop of that id.
- `action_valid[i] = ~req[i] & ~queued[i] & ~flush`. This output is combinational from registers plus `flush`.
- Pop: when `act_valid && act_ready`, the head is removed and the next entry is presented on the following cycle.
- Push and pop in the same cycle are both performed; the count is unchanged. A push into a full FIFO cannot happen because the scheduler blocks it. When full, requests stay latched in `req`.
- Flush has priority over pulse capture, push, and pop. At the edge with `flush=1`, `req`, `queued`, the FIFO pointers, and the count all clear. An action popped in the flush cycle still counts as consumed by the consumer.
- Arithmetic:
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - Count is $clog2(DEPTH)+1 bits and ranges 0..DEPTH.
  - Full is count==DEPTH; empty is count==0.

## Timing
- Reset values: `req=0`, `queued=0`, pointers and count 0, `act_valid=0`, `act_id=0`, `queue_count=0`, `action_valid` all ones (with `flush=0`).
- Latency with an empty queue and no competing requests: pulse in cycle t → `req[i]=1` and `action_valid[i]=0` in t+1 → `act_valid=1`, `act_id=i` in t+2.
- `act_valid`/`act_id` are registered FIFO-head outputs. `act_id` is held stable while `act_valid && !act_ready`.
- `action_valid[i]` returns to 1 in the cycle after the pop of id i.
- Flush in cycle t gives `act_valid=0` and all `action_valid=1` in t+1. `action_valid` is 0 during t itself.
- Asynchronous reset mid-operation discards everything immediately. There is no partial-state recovery.

## Structure
- Shared package `tetris_input_pkg`:
  - `action_t` enum: MOVE_LEFT=0, MOVE_RIGHT, ROTATE_CW, ROTATE_CCW, SOFT_DROP, HARD_DROP.
  - `NUM_ACTIONS` constant.
  - `action_id_t` typedef.
- One sub-module, `action_fifo`: a synchronous DEPTH×id-width FIFO with push, pop, clear, full, empty, and count. It instantiates the existing `counter` for the pointers.
- The scheduler, request latch, and `queued` tracking live in the top level.

## Test plan
- Reset: assert `rst` mid-stream with 3 entries queued → `act_valid=0`, `queue_count=0`, `action_valid=6'b111111` immediately.
- Single action: pulse bit 2 at t with `act_ready=1` → `act_valid=1`, `act_id=2` at t+2. `action_valid[2]=0` in t+1..t+2 and 1 at t+3.
- Simultaneous pulses: bits 0, 3, 5 in one cycle with `act_ready=0` → FIFO receives 0, 3, 5 on consecutive cycles. Raising ready pops ids 0, 3, 5 in order.
- Full queue: DEPTH=4, `act_ready=0`, pulse ids 0..4 → `queue_count=4` and id 4 held in `req`. One pop lets id 4 enter the next cycle.
- Dropped pulse: pulse id 1 twice while it is queued → only one id-1 entry is ever popped.
- Flush: 3 entries queued, `req[5]` pending, `flush` for one cycle together with `act_ready=1` → the head is popped, then `act_valid=0`, `queue_count=0`, and id 5 is never emitted.
